// File: rtl/led_pwm_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg (package)
// Purpose  : Shared definitions for the led_pwm_scan engine: mode encodings,
//            loader state type and index-width helpers.
// Ports    : n/a (package)
// Revision : 1.0 - initial parametrised release
// ============================================================================
package led_pkg;

  // Pixel conversion modes (2'b11 behaves as raw)
  localparam logic [1:0] MODE_RAW        = 2'b00;
  localparam logic [1:0] MODE_HALF_DITH  = 2'b01;
  localparam logic [1:0] MODE_HALF_TRUNC = 2'b10;

  // Loader state: accepting words, or shadow bank complete
  typedef enum logic [0:0] {
    LOAD = 1'b0,
    FULL = 1'b1
  } load_state_t;

  // Index width for a count of n items; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index widths for the default geometry (16 channels, 32 scan lines)
  localparam int CH_IDX_W = idx_w(16);
  localparam int SL_IDX_W = idx_w(32);

endpackage
`default_nettype wire

// File: rtl/led_pwm_scan_gray_conv.sv
`default_nettype none
// ============================================================================
// Module   : led_gray_conv
// Purpose  : Combinational gray-level conversion applied at shadow write time.
//            Raw pass-through, half depth with round/truncate alternating on
//            frame_tog, or half depth truncate-only.
// Ports    : mode      - conversion mode (see led_pkg)
//            frame_tog - frame parity; 0 rounds, 1 truncates in dither mode
//            din       - incoming gray value
//            dout      - converted gray value (same width, cannot overflow)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module led_gray_conv
  import led_pkg::*;
#(
  parameter int GW = 16
) (
  input  logic [1:0]    mode,
  input  logic          frame_tog,
  input  logic [GW-1:0] din,
  output logic [GW-1:0] dout
);

  always_comb begin
    dout = din;
    case (mode)
      // Rounding on even frames and truncation on odd frames averages out
      // the lost LSB over a frame pair.
      MODE_HALF_DITH:  dout = (din >> 1) + GW'(din[0] & ~frame_tog);
      MODE_HALF_TRUNC: dout = din >> 1;
      default:         dout = din;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/led_pwm_scan.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_scan
// Purpose  : Grayscale PWM scan engine. Pixel words stream into a shadow bank,
//            are committed to the active bank on line_start, and drive CH
//            comparator outputs against a saturating PWM counter.
// Macro    : LED_PWM_BLANK_EN - when defined, BLANK cycles of forced-low
//            output follow every commit before PWM counting starts.
// Ports    : GCK        - block clock
//            rst        - synchronous active-high reset
//            pix_valid  - pixel word valid
//            pix_ready  - block can accept a pixel word
//            pix_data   - gray value for the next channel index
//            line_start - strobe: commit shadow to active, start a PWM line
//            mode       - conversion mode (00/11 raw, 01 dither, 10 trunc)
//            OUT        - registered PWM outputs, OUT[i] = active[i] > pwm_cnt
//            line_idx   - current scan line
//            frame_tog  - toggles whenever line_idx wraps to 0
//            underrun   - sticky: strobe arrived before shadow bank was full
// Revision : 1.0 - initial parametrised release
// ============================================================================
module led_pwm_scan
  import led_pkg::*;
#(
  parameter int CH    = 16,
  parameter int GW    = 16,
  parameter int SL    = 32,
  parameter int BLANK = 4
) (
  input  logic                  GCK,
  input  logic                  rst,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [GW-1:0]         pix_data,
  input  logic                  line_start,
  input  logic [1:0]            mode,
  output logic [CH-1:0]         OUT,
  output logic [idx_w(SL)-1:0]  line_idx,
  output logic                  frame_tog,
  output logic                  underrun
);

  localparam int            CW      = idx_w(CH);
  localparam int            LW      = idx_w(SL);
  localparam logic [GW-1:0] PWM_MAX = '1;

  load_state_t   state;
  logic [CW-1:0] wr_idx;
  logic [GW-1:0] shadow [CH];
  logic [GW-1:0] active [CH];
  logic [GW-1:0] pwm_cnt;
  logic [GW-1:0] conv_data;
  logic [CH-1:0] cmp;
  logic          hs;
  logic          pwm_hold;
  logic          out_force;

  assign hs = pix_valid & pix_ready;

  led_gray_conv #(
    .GW (GW)
  ) u_conv (
    .mode      (mode),
    .frame_tog (frame_tog),
    .din       (pix_data),
    .dout      (conv_data)
  );

  // --------------------------------------------------------------------------
  // Loader FSM with registered ready. A strobe always restarts loading; a
  // same-cycle handshake lands in slot 0 (the commit still sees the old bank).
  // --------------------------------------------------------------------------
  always_ff @(posedge GCK) begin
    if (rst) begin
      state     <= LOAD;
      pix_ready <= 1'b1;
      wr_idx    <= '0;
      for (int i = 0; i < CH; i++) shadow[i] <= '0;
    end else if (line_start) begin
      state     <= LOAD;
      pix_ready <= 1'b1;
      if (hs) begin
        shadow[0] <= conv_data;
        wr_idx    <= CW'(1);
      end else begin
        wr_idx    <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (hs) begin
            shadow[wr_idx] <= conv_data;
            wr_idx         <= wr_idx + 1'b1;
            if (wr_idx == CW'(CH - 1)) begin
              state     <= FULL;
              pix_ready <= 1'b0;
            end
          end
        end
        FULL: begin
          pix_ready <= 1'b0;
        end
        default: begin
          state     <= LOAD;
          pix_ready <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Optional post-commit blanking
  // --------------------------------------------------------------------------
`ifdef LED_PWM_BLANK_EN
  localparam int BW = idx_w(BLANK + 1);
  logic [BW-1:0] blank_cnt;
  logic          blank_act;

  assign blank_act = (blank_cnt != '0);

  always_ff @(posedge GCK) begin
    if (rst)             blank_cnt <= '0;
    else if (line_start) blank_cnt <= BW'(BLANK);
    else if (blank_act)  blank_cnt <= blank_cnt - 1'b1;
  end

  // Outputs also drop on the commit edge so the whole blank window is dark
  assign pwm_hold  = blank_act;
  assign out_force = blank_act | line_start;
`else
  logic unused_blank;
  assign unused_blank = (BLANK != 0);
  assign pwm_hold     = 1'b0;
  assign out_force    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Commit, line tracking and PWM counter
  // --------------------------------------------------------------------------
  always_ff @(posedge GCK) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) active[i] <= '0;
      pwm_cnt   <= '0;
      line_idx  <= '0;
      frame_tog <= 1'b0;
      underrun  <= 1'b0;
    end else if (line_start) begin
      for (int i = 0; i < CH; i++) active[i] <= shadow[i];
      pwm_cnt <= '0;
      if (state == LOAD) underrun <= 1'b1;
      if (line_idx == LW'(SL - 1)) begin
        line_idx  <= '0;
        frame_tog <= ~frame_tog;
      end else begin
        line_idx  <= line_idx + 1'b1;
      end
    end else if (!pwm_hold && (pwm_cnt != PWM_MAX)) begin
      // Saturating: at PWM_MAX no channel compares greater, so OUT stays low
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel comparators and registered outputs
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < CH; i++) begin : g_cmp
    assign cmp[i] = (active[i] > pwm_cnt);
  end

  always_ff @(posedge GCK) begin
    if (rst)            OUT <= '0;
    else if (out_force) OUT <= '0;
    else                OUT <= cmp;
  end

endmodule
`default_nettype wire
